// File: rtl/lotr_pkg.sv
// Shared LOTR ring types and constants.
// Contents: t_opcode (RD, RD_RSP, WR, WR_RSP), t_ring_pkt (one ring slot),
//           RING_ID_MSB/RING_ID_LSB (address bits that select the target ring stop).
package lotr_pkg;

    typedef enum logic [1:0] {
        RD     = 2'd0,
        RD_RSP = 2'd1,
        WR     = 2'd2,
        WR_RSP = 2'd3
    } t_opcode;

    typedef struct packed {
        logic        valid;
        logic [9:0]  requestor;
        t_opcode     opcode;
        logic [31:0] address;
        logic [31:0] data;
    } t_ring_pkt;

    localparam int unsigned RING_ID_MSB = 31;
    localparam int unsigned RING_ID_LSB = 24;

endpackage

// File: rtl/ring_mem_responder_if.sv
// Ring-side signal bundle of ring_mem_responder.
// slave modport: seen by the ring stop (ReqIn/RspIn in, ReqOut/RspOut out).
// master modport: seen by whatever drives the ring around the stop.
// Optional build macro LOTR_RESP_STATS_EN adds RspBounceCntQ502H and RspFifoMaxQ502H.
interface ring_mem_responder_if #(
    parameter int unsigned RSP_FIFO_DEPTH = 4
);
    import lotr_pkg::*;

    logic        RingReqInValidQ500H;
    logic [9:0]  RingReqInRequestorQ500H;
    t_opcode     RingReqInOpcodeQ500H;
    logic [31:0] RingReqInAddressQ500H;
    logic [31:0] RingReqInDataQ500H;

    logic        RingRspInValidQ500H;
    logic [9:0]  RingRspInRequestorQ500H;
    t_opcode     RingRspInOpcodeQ500H;
    logic [31:0] RingRspInAddressQ500H;
    logic [31:0] RingRspInDataQ500H;

    logic        RingReqOutValidQ502H;
    logic [9:0]  RingReqOutRequestorQ502H;
    t_opcode     RingReqOutOpcodeQ502H;
    logic [31:0] RingReqOutAddressQ502H;
    logic [31:0] RingReqOutDataQ502H;

    logic        RingRspOutValidQ502H;
    logic [9:0]  RingRspOutRequestorQ502H;
    t_opcode     RingRspOutOpcodeQ502H;
    logic [31:0] RingRspOutAddressQ502H;
    logic [31:0] RingRspOutDataQ502H;

`ifdef LOTR_RESP_STATS_EN
    logic [15:0]                           RspBounceCntQ502H;
    logic [$clog2(RSP_FIFO_DEPTH+1)-1:0]   RspFifoMaxQ502H;
`endif

    modport slave (
        input  RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
               RingReqInAddressQ500H, RingReqInDataQ500H,
        input  RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
               RingRspInAddressQ500H, RingRspInDataQ500H,
        output RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
               RingReqOutAddressQ502H, RingReqOutDataQ502H,
        output RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
               RingRspOutAddressQ502H, RingRspOutDataQ502H
`ifdef LOTR_RESP_STATS_EN
        , output RspBounceCntQ502H, RspFifoMaxQ502H
`endif
    );

    modport master (
        output RingReqInValidQ500H, RingReqInRequestorQ500H, RingReqInOpcodeQ500H,
               RingReqInAddressQ500H, RingReqInDataQ500H,
        output RingRspInValidQ500H, RingRspInRequestorQ500H, RingRspInOpcodeQ500H,
               RingRspInAddressQ500H, RingRspInDataQ500H,
        input  RingReqOutValidQ502H, RingReqOutRequestorQ502H, RingReqOutOpcodeQ502H,
               RingReqOutAddressQ502H, RingReqOutDataQ502H,
        input  RingRspOutValidQ502H, RingRspOutRequestorQ502H, RingRspOutOpcodeQ502H,
               RingRspOutAddressQ502H, RingRspOutDataQ502H
`ifdef LOTR_RESP_STATS_EN
        , input RspBounceCntQ502H, RspFifoMaxQ502H
`endif
    );

endinterface

// File: rtl/ring_rsp_fifo.sv
// Queue of local responses waiting for a free response-ring slot.
// Ports: QClk/RstQnnnL clock and async active-low reset; push/pushData write side;
//        pop/popData read side (popData is the head, valid while !empty);
//        count/full/empty occupancy. Push and pop may happen in the same cycle.
module ring_rsp_fifo
    import lotr_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                         QClk,
    input  logic                         RstQnnnL,
    input  logic                         push,
    input  t_ring_pkt                    pushData,
    input  logic                         pop,
    output t_ring_pkt                    popData,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    t_ring_pkt           entries [DEPTH];
    logic [PtrW-1:0]     wrPtr;
    logic [PtrW-1:0]     rdPtr;
    logic [CntW-1:0]     countQ;

    // DEPTH need not be a power of two, so wrap explicitly.
    function automatic logic [PtrW-1:0] nextPtr(input logic [PtrW-1:0] ptr);
        return (ptr == PtrW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
    endfunction

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            wrPtr  <= '0;
            rdPtr  <= '0;
            countQ <= '0;
        end else begin
            if (push) wrPtr <= nextPtr(wrPtr);
            if (pop)  rdPtr <= nextPtr(rdPtr);
            if (push && !pop)      countQ <= countQ + 1'b1;
            else if (pop && !push) countQ <= countQ - 1'b1;
        end
    end

    // Storage carries no reset; the pointers define what is live.
    always_ff @(posedge QClk) begin
        if (push) entries[wrPtr] <= pushData;
    end

    assign popData = entries[rdPtr];
    assign count   = countQ;
    assign full    = (countQ == CntW'(DEPTH));
    assign empty   = (countQ == '0);

    noOverflow: assert property (@(posedge QClk) disable iff (!RstQnnnL) !(push && !pop && full));
    noUnderflow: assert property (@(posedge QClk) disable iff (!RstQnnnL) !(pop && empty));

endmodule

// File: rtl/ring_mem_responder.sv
// LOTR ring stop serving RD/WR requests addressed to TILE_ID from a local word array.
// Ports: QClk clock, RstQnnnL async active-low reset, ring (ring_mem_responder_if.slave):
//        ReqIn/RspIn slots at Q500H, ReqOut/RspOut slots at Q502H.
// Non-matching traffic passes through with exactly two cycles of latency. Matching requests
// are consumed and answered on the response ring; responses that cannot get a slot wait in
// ring_rsp_fifo. Build macro LOTR_RESP_STATS_EN adds bounce-count and FIFO high-water outputs.
module ring_mem_responder
    import lotr_pkg::*;
#(
    parameter logic [7:0]  TILE_ID        = 8'hF0,
    parameter int unsigned MEM_WORDS      = 1024,
    parameter int unsigned RSP_FIFO_DEPTH = 4
) (
    input logic                  QClk,
    input logic                  RstQnnnL,
    ring_mem_responder_if.slave  ring
);
    localparam int unsigned IdxW = $clog2(MEM_WORDS);
    localparam int unsigned CntW = $clog2(RSP_FIFO_DEPTH + 1);

    t_ring_pkt reqIn, rspIn;
    t_ring_pkt s1Fwd, s1Rsp, s1Local;   // Q501H
    t_ring_pkt s2Req, s2Rsp;            // Q502H
    t_ring_pkt localRsp, arbRsp, fifoHead;

    logic            reqMatch, fifoRoom, reqHit;
    logic            fifoPush, fifoPop, fifoFull, fifoEmpty;
    logic [CntW-1:0] fifoCount;

    logic [31:0]     mem [MEM_WORDS];
    logic [IdxW-1:0] s1Idx;
    logic [31:0]     rdWord;

    assign reqIn = '{valid: ring.RingReqInValidQ500H, requestor: ring.RingReqInRequestorQ500H,
                     opcode: ring.RingReqInOpcodeQ500H, address: ring.RingReqInAddressQ500H,
                     data: ring.RingReqInDataQ500H};
    assign rspIn = '{valid: ring.RingRspInValidQ500H, requestor: ring.RingRspInRequestorQ500H,
                     opcode: ring.RingRspInOpcodeQ500H, address: ring.RingRspInAddressQ500H,
                     data: ring.RingRspInDataQ500H};

    // Reserve a FIFO entry for every accepted request that has not yet reached the ring,
    // including the one in Q501H; this is what makes overflow impossible.
    assign reqMatch = reqIn.valid && (reqIn.opcode == RD || reqIn.opcode == WR) &&
                      (reqIn.address[RING_ID_MSB:RING_ID_LSB] == TILE_ID);
    assign fifoRoom = (32'(fifoCount) + 32'(s1Local.valid)) < RSP_FIFO_DEPTH;
    assign reqHit   = reqMatch && fifoRoom;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            s1Fwd   <= '0;
            s1Rsp   <= '0;
            s1Local <= '0;
            s2Req   <= '0;
            s2Rsp   <= '0;
        end else begin
            s1Fwd   <= reqHit ? '0 : reqIn;
            s1Rsp   <= rspIn;
            s1Local <= reqHit ? reqIn : '0;
            s2Req   <= s1Fwd;
            s2Rsp   <= arbRsp;
        end
    end

    // Word array: write at the edge ending Q501H, asynchronous read during Q501H.
    assign s1Idx  = s1Local.address[IdxW+1:2];
    assign rdWord = mem[s1Idx];

    always_ff @(posedge QClk) begin
        if (s1Local.valid && s1Local.opcode == WR) mem[s1Idx] <= s1Local.data;
    end

    always_comb begin
        localRsp = s1Local;
        if (s1Local.opcode == WR) begin
            localRsp.opcode = WR_RSP;
        end else begin
            localRsp.opcode = RD_RSP;
            localRsp.data   = rdWord;
        end
    end

    // Slot priority: forwarded RspIn, then FIFO head, then bypass of the new response.
    always_comb begin
        arbRsp   = s1Rsp;
        fifoPop  = 1'b0;
        fifoPush = 1'b0;
        if (s1Rsp.valid) begin
            fifoPush = s1Local.valid;
        end else if (!fifoEmpty) begin
            arbRsp   = fifoHead;
            fifoPop  = 1'b1;
            fifoPush = s1Local.valid;
        end else if (s1Local.valid) begin
            arbRsp = localRsp;
        end
    end

    ring_rsp_fifo #(
        .DEPTH (RSP_FIFO_DEPTH)
    ) rspFifo (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .push     (fifoPush),
        .pushData (localRsp),
        .pop      (fifoPop),
        .popData  (fifoHead),
        .count    (fifoCount),
        .full     (fifoFull),
        .empty    (fifoEmpty)
    );

    assign ring.RingReqOutValidQ502H     = s2Req.valid;
    assign ring.RingReqOutRequestorQ502H = s2Req.requestor;
    assign ring.RingReqOutOpcodeQ502H    = s2Req.opcode;
    assign ring.RingReqOutAddressQ502H   = s2Req.address;
    assign ring.RingReqOutDataQ502H      = s2Req.data;

    assign ring.RingRspOutValidQ502H     = s2Rsp.valid;
    assign ring.RingRspOutRequestorQ502H = s2Rsp.requestor;
    assign ring.RingRspOutOpcodeQ502H    = s2Rsp.opcode;
    assign ring.RingRspOutAddressQ502H   = s2Rsp.address;
    assign ring.RingRspOutDataQ502H      = s2Rsp.data;

`ifdef LOTR_RESP_STATS_EN
    logic [15:0]     bounceCnt;
    logic [CntW-1:0] fifoMax;

    always_ff @(posedge QClk or negedge RstQnnnL) begin
        if (!RstQnnnL) begin
            bounceCnt <= '0;
            fifoMax   <= '0;
        end else begin
            if (reqMatch && !fifoRoom && bounceCnt != '1) bounceCnt <= bounceCnt + 1'b1;
            if (fifoCount > fifoMax) fifoMax <= fifoCount;
        end
    end

    assign ring.RspBounceCntQ502H = bounceCnt;
    assign ring.RspFifoMaxQ502H   = fifoMax;
`endif

    // Full-flag is implied by the reservation rule; keep it observable for the assertion.
    fullNeverPushed: assert property (@(posedge QClk) disable iff (!RstQnnnL)
                                      !(fifoFull && fifoPush && !fifoPop));

endmodule

// File: tb/tb_ring_mem_responder.sv
module tb_ring_mem_responder;
    import lotr_pkg::*;

    localparam int unsigned Depth = 4;
    localparam int unsigned Words = 1024;

    logic QClk = 1'b0;
    logic RstQnnnL = 1'b0;
    always #5 QClk = ~QClk;

    ring_mem_responder_if #(.RSP_FIFO_DEPTH(Depth)) ringIf ();

    ring_mem_responder #(
        .TILE_ID        (8'hF0),
        .MEM_WORDS      (Words),
        .RSP_FIFO_DEPTH (Depth)
    ) dut (
        .QClk     (QClk),
        .RstQnnnL (RstQnnnL),
        .ring     (ringIf.slave)
    );

    int nChecks = 0;
    int nFails  = 0;

    // Reference model state: responses produced but not yet on the ring, in order.
    t_ring_pkt   pending[$];
    logic [31:0] memModel [int];
    t_ring_pkt   accepted;      // request consumed last cycle, answered this cycle
    t_ring_pkt   prevRspIn;
    t_ring_pkt   reqLater;      // ReqOut expected one cycle from now
    t_ring_pkt   idle;

    function automatic t_ring_pkt mk(input logic v, input logic [9:0] rq, input t_opcode op,
                                     input logic [31:0] a, input logic [31:0] d);
        t_ring_pkt p;
        p.valid = v; p.requestor = rq; p.opcode = op; p.address = a; p.data = d;
        return p;
    endfunction

    function automatic t_ring_pkt obsReq();
        return mk(ringIf.RingReqOutValidQ502H, ringIf.RingReqOutRequestorQ502H,
                  ringIf.RingReqOutOpcodeQ502H, ringIf.RingReqOutAddressQ502H,
                  ringIf.RingReqOutDataQ502H);
    endfunction

    function automatic t_ring_pkt obsRsp();
        return mk(ringIf.RingRspOutValidQ502H, ringIf.RingRspOutRequestorQ502H,
                  ringIf.RingRspOutOpcodeQ502H, ringIf.RingRspOutAddressQ502H,
                  ringIf.RingRspOutDataQ502H);
    endfunction

    task automatic check(input string tag, input t_ring_pkt obs, input t_ring_pkt exp);
        nChecks++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input t_ring_pkt rq, input t_ring_pkt rs);
        ringIf.RingReqInValidQ500H     = rq.valid;
        ringIf.RingReqInRequestorQ500H = rq.requestor;
        ringIf.RingReqInOpcodeQ500H    = rq.opcode;
        ringIf.RingReqInAddressQ500H   = rq.address;
        ringIf.RingReqInDataQ500H      = rq.data;
        ringIf.RingRspInValidQ500H     = rs.valid;
        ringIf.RingRspInRequestorQ500H = rs.requestor;
        ringIf.RingRspInOpcodeQ500H    = rs.opcode;
        ringIf.RingRspInAddressQ500H   = rs.address;
        ringIf.RingRspInDataQ500H      = rs.data;
    endtask

    // One ring cycle: present inputs, advance the model, check both output slots.
    task automatic step(input string tag, input t_ring_pkt rq, input t_ring_pkt rs);
        t_ring_pkt r, rspNow, reqNow;
        int idx;
        logic match, hit;
        drive(rq, rs);
        // Answer last cycle's consumed request against the array.
        if (accepted.valid) begin
            idx = int'(accepted.address[11:2]);
            r = accepted;
            if (accepted.opcode == WR) begin
                memModel[idx] = accepted.data;
                r.opcode = WR_RSP;
            end else begin
                r.opcode = RD_RSP;
                r.data = memModel[idx];
            end
            pending.push_back(r);
        end
        // Consume only if every outstanding response still fits in the queue.
        match = rq.valid && (rq.opcode == RD || rq.opcode == WR) && rq.address[31:24] == 8'hF0;
        hit = match && (pending.size() < Depth);
        accepted = hit ? rq : idle;
        // Passing traffic owns the slot; otherwise the oldest local response goes.
        if (prevRspIn.valid)        rspNow = prevRspIn;
        else if (pending.size() > 0) rspNow = pending.pop_front();
        else                        rspNow = prevRspIn;
        prevRspIn = rs;
        reqNow = reqLater;
        reqLater = hit ? idle : rq;
        @(posedge QClk);
        #1;
        check({tag, " reqOut"}, obsReq(), reqNow);
        check({tag, " rspOut"}, obsRsp(), rspNow);
    endtask

    task automatic modelReset();
        pending.delete();
        accepted  = idle;
        prevRspIn = idle;
        reqLater  = idle;
    endtask

    initial begin
        t_ring_pkt rq, rs;
        int idx, sel;
        idle = '0;
        modelReset();
        drive(idle, idle);
        repeat (2) @(posedge QClk);
        #1;
        check("reset reqOut", obsReq(), idle);
        check("reset rspOut", obsRsp(), idle);
        RstQnnnL = 1'b1;

        // Local write, then read-back of the same word.
        step("t1 wr", mk(1, 10'h005, WR, 32'hF000_0010, 32'hCAFE_F00D), idle);
        step("t1 idle", idle, idle);
        check("t1 wrRsp", obsRsp(), mk(1, 10'h005, WR_RSP, 32'hF000_0010, 32'hCAFE_F00D));
        check("t1 bubble", obsReq(), idle);
        step("t2 rd", mk(1, 10'h00A, RD, 32'hF000_0010, 32'h0), idle);
        step("t2 idle", idle, idle);
        check("t2 rdRsp", obsRsp(), mk(1, 10'h00A, RD_RSP, 32'hF000_0010, 32'hCAFE_F00D));

        // Foreign request passes through untouched.
        step("t3 fwd", mk(1, 10'h077, RD, 32'h0100_0000, 32'h1234_5678), idle);
        step("t3 idle", idle, idle);
        check("t3 fwdReq", obsReq(), mk(1, 10'h077, RD, 32'h0100_0000, 32'h1234_5678));
        check("t3 noRsp", obsRsp(), idle);

        // Busy response ring: four queue up, the fifth is bounced.
        for (int i = 0; i < 6; i++) begin
            rq = (i < 5) ? mk(1, 10'(i + 1), RD, 32'hF000_0010, 32'h0) : idle;
            rs = mk(1, 10'h300 + 10'(i), RD_RSP, 32'h0200_0000 + 32'(i), 32'hA000_0000 + 32'(i));
            step("t4 busy", rq, rs);
        end
        for (int i = 0; i < 8; i++) step("t4 drain", idle, idle);

        // Passing response wins the slot over a same-cycle local hit.
        step("t5 both", mk(1, 10'h011, RD, 32'hF000_0010, 32'h0),
             mk(1, 10'h222, WR_RSP, 32'h0300_0000, 32'h5555_AAAA));
        for (int i = 0; i < 3; i++) step("t5 idle", idle, idle);

        // Reset with responses queued: outputs clear at once, nothing stale afterwards.
        for (int i = 0; i < 4; i++) begin
            rq = (i < 3) ? mk(1, 10'h040 + 10'(i), RD, 32'hF000_0010, 32'h0) : idle;
            rs = mk(1, 10'h100, RD_RSP, 32'h0400_0000, 32'h0BAD_0000 + 32'(i));
            step("t6 fill", rq, rs);
        end
        drive(idle, idle);
        RstQnnnL = 1'b0;
        #1;
        check("t6 rstReq", obsReq(), idle);
        check("t6 rstRsp", obsRsp(), idle);
        modelReset();
        @(posedge QClk);
        #1;
        RstQnnnL = 1'b1;
        for (int i = 0; i < 6; i++) step("t6 after", idle, idle);

        // Random traffic mix against the model.
        for (int n = 0; n < 400; n++) begin
            rq = idle;
            rs = idle;
            if ($urandom_range(99) < 70) begin
                rq.valid = 1'b1;
                rq.requestor = 10'($urandom);
                rq.data = $urandom;
                sel = int'($urandom_range(9));
                if (sel < 6) begin
                    idx = int'($urandom_range(7));
                    rq.address = {8'hF0, 12'($urandom), 10'(idx), 2'b00};
                    rq.opcode = (memModel.exists(idx) && $urandom_range(1) == 1) ? RD : WR;
                end else if (sel < 8) begin
                    rq.address = $urandom;
                    if (rq.address[31:24] == 8'hF0) rq.address[31:24] = 8'h12;
                    rq.opcode = ($urandom_range(1) == 1) ? RD : WR;
                end else begin
                    rq.address = {8'hF0, 24'($urandom)};
                    rq.opcode = ($urandom_range(1) == 1) ? RD_RSP : WR_RSP;
                end
            end
            if ($urandom_range(99) < 40) begin
                rs.valid = 1'b1;
                rs.requestor = 10'($urandom);
                rs.opcode = ($urandom_range(1) == 1) ? RD_RSP : WR_RSP;
                rs.address = $urandom;
                rs.data = $urandom;
            end
            step("rand", rq, rs);
        end
        for (int i = 0; i < 10; i++) step("rand drain", idle, idle);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
